imem_sync_loader: RTL and testbench
===================================

Name: imem_sync_loader

Overview:
- Next-generation instruction memory for the 5-stage RISC-V pipeline. Replaces the combinational, initial-block-loaded array with a parametrised synchronous-read memory.
- Fetch side: byte-addressed, registered, with stall and flush handling and misalignment/range fault reporting.
- Load side: a byte-serial program-load port, fed by a UART/boot controller, writes words into the array at run time. No recompilation is needed to change the program.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses on the fetch and load ports.
- INST_WIDTH, 32, instruction width; fixed at 32 (four load bytes per word).
- IMEM_DEPTH, 1024, number of words in the array; power of two.
- NOP_INST, 32'h00000013, value driven on instruction when invalid, faulted or flushed (addi x0,x0,0).
- LEN_WIDTH, 16, width of the load length field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_WIDTH  byte address from the PC.
- stall  in  1  hold the IF/ID output; ignore fetch_req.
- flush  in  1  kill the in-flight fetch.
- fetch_ready  out  1  fetch accepted this cycle (combinational).
- inst_valid  out  1  instruction/inst_addr are valid.
- instruction  out  INST_WIDTH  fetched word.
- inst_addr  out  ADDR_WIDTH  byte address of the fetched word.
- fetch_fault  out  1  the fetched address was misaligned or out of range.
- load_start  in  1  begin a program load.
- load_base  in  ADDR_WIDTH  byte base address of the load; bits [1:0] ignored.
- load_len  in  LEN_WIDTH  number of words to load.
- load_byte_valid  in  1  a load byte is present.
- load_byte  in  8  load data byte.
- load_busy  out  1  load FSM is not in RUN.
- load_done  out  1  one-cycle pulse at load completion.
- load_err  out  1  sticky out-of-range write flag.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to RUN.
  - inst_valid=0, instruction=NOP_INST, inst_addr=0, fetch_fault=0.
  - load_busy=0, load_done=0, load_err=0.
  - Byte counter, word counter and assembly register are cleared.
  - Array contents are NOT reset. Contents come from INIT_FILE-free zero init or from a prior load.
- Word index: idx = fetch_addr >> 2.
- fetch_ready = (state==RUN) & ~load_start & ~stall.
- Fetch latency is 1 cycle. On a clock edge with fetch_ready & fetch_req:
  - inst_valid <= 1; inst_addr <= fetch_addr.
  - If fetch_addr[1:0] != 0 or idx >= IMEM_DEPTH: fetch_fault <= 1 and instruction <= NOP_INST.
  - Otherwise: fetch_fault <= 0 and instruction <= mem[idx].
- RUN, no stall, and (~fetch_req or load_start): inst_valid <= 0, instruction <= NOP_INST, fetch_fault <= 0.
- stall=1 without flush: all fetch outputs hold their values; fetch_req is ignored.
- flush=1 (has priority over stall and over fetch_req in the same cycle): inst_valid <= 0, instruction <= NOP_INST, fetch_fault <= 0. The request presented that cycle is dropped.
- FSM states: RUN, LOAD, DONE.
- RUN -> LOAD on load_start:
  - Latch base word index = load_base >> 2 and the length.
  - Clear byte_cnt and word_cnt; clear load_err.
  - If load_start coincides with fetch_req, the load wins and the fetch is dropped (fetch_ready=0).
- load_len == 0: RUN -> DONE directly. No writes occur.
- LOAD, on each load_byte_valid:
  - The byte goes into lane byte_cnt (little-endian: byte 0 -> bits [7:0]).
  - byte_cnt increments modulo 4.
  - On the 4th byte, write the assembled word to mem[base+word_cnt] in that same edge, then word_cnt += 1.
  - If base+word_cnt >= IMEM_DEPTH, the write is suppressed and load_err <= 1. load_err stays set until the next load_start or rst.
  - No wrap-around of the write address.
- LOAD -> DONE on the edge that writes (or suppresses) word load_len-1.
- DONE -> RUN after one cycle. load_done=1 only in DONE.
- load_busy = (state != RUN).
- While load_busy: inst_valid forced to 0 and fetch_ready=0. The pipeline must stall.
- load_start while busy is ignored.
- load_byte_valid in RUN or DONE is ignored.
- rst mid-load: the FSM aborts to RUN. The partial word is discarded; words already written remain.
- Read and write never coincide, because fetch is blocked during LOAD.
- Array write is one port, read is one port. Inference as block RAM is required: registered read, no combinational read path.

Test Plan:
- Load, then fetch: rst, then load_start with base=0x0 and len=2; bytes 93,00,10,00,13,01,f0,01.
  - Required: load_done pulses after the 8th byte.
  - Required: fetch 0x0 returns 0x00100093 one cycle later, and fetch 0x4 returns 0x01f00113, both with inst_valid=1 and fetch_fault=0.
- Misaligned and out-of-range fetch: fetch 0x2 -> fetch_fault=1, instruction=0x00000013, inst_valid=1. fetch 0x1000 with depth 1024 -> fetch_fault=1.
- Stall and flush: fetch 0x0, then stall=1 for 3 cycles while changing fetch_addr -> outputs hold 0x00100093. flush=1 with stall=1 -> inst_valid=0 on the next cycle.
- Load overflow: base=0xFFC, len=2 -> the word at index 1023 is written, the second word is suppressed, load_err=1, load_done pulses. load_err clears on the next load_start.
- Reset mid-load and collision: rst after 2 bytes of the first word -> load_busy=0 and mem[0] unchanged. load_start together with fetch_req -> fetch_ready=0, inst_valid=0 on the next cycle, load_busy=1.
- Zero-length and ignored inputs: load_start with len=0 -> DONE the next cycle and load_done=1, no writes. load_byte_valid in RUN -> memory unchanged.

Source files
------------

// File: rtl/imem_sync_loader.sv
// Synchronous-read instruction memory with a registered fetch port and a
// byte-serial program-load port that writes whole words at run time.
module imem_sync_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    IMEM_DEPTH = 1024,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013,
  parameter int                    LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  fetch_ready,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  fetch_fault,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH;

  typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

  state_t                  state, state_next;
  logic [INST_WIDTH-1:0]   mem [IMEM_DEPTH];
  logic [INST_WIDTH-1:0]   rd_word;
  logic                    from_mem;
  logic [ADDR_WIDTH-3:0]   base_idx;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    word_cnt;
  logic [1:0]              byte_cnt;
  logic [23:0]             asm_q;
  logic [SUM_W-1:0]        wr_sum;
  logic                    wr_in_range;
  logic                    byte_last;
  logic                    word_last;
  logic                    mem_we;
  logic                    fetch_take;
  logic                    fetch_bad;
  logic [IDX_W-1:0]        fetch_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic [INST_WIDTH-1:0]   wr_word;
  logic                    unused_base;

  assign unused_base = ^load_base[1:0];

  assign fetch_idx  = fetch_addr[IDX_W+1:2];
  assign fetch_bad  = (fetch_addr[1:0] != 2'b00) ||
                      ((fetch_addr >> 2) >= ADDR_WIDTH'(IMEM_DEPTH));
  assign fetch_take = fetch_ready & fetch_req;

  // Write address never wraps: the sum is wide enough to see past the array end.
  assign wr_sum      = SUM_W'(base_idx) + SUM_W'(word_cnt);
  assign wr_in_range = wr_sum < SUM_W'(IMEM_DEPTH);
  assign wr_idx      = wr_sum[IDX_W-1:0];
  assign wr_word     = {load_byte, asm_q};
  assign byte_last   = (byte_cnt == 2'd3);
  assign word_last   = (word_cnt == len_q - LEN_WIDTH'(1));

  assign instruction = from_mem ? rd_word : NOP_INST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_we      = 1'b0;
    fetch_ready = 1'b0;
    load_busy   = 1'b1;
    load_done   = 1'b0;
    case (state)
      RUN: begin
        load_busy   = 1'b0;
        fetch_ready = ~load_start & ~stall;
        if (load_start) state_next = (load_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (load_byte_valid && byte_last) begin
          mem_we = wr_in_range;
          if (word_last) state_next = DONE;
        end
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_idx <= '0;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      load_err <= 1'b0;
    end else if (state == RUN && load_start) begin
      base_idx <= load_base[ADDR_WIDTH-1:2];
      len_q    <= load_len;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      load_err <= 1'b0;
    end else if (state == LOAD && load_byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    asm_q[7:0]   <= load_byte;
        2'd1:    asm_q[15:8]  <= load_byte;
        2'd2:    asm_q[23:16] <= load_byte;
        default: ;
      endcase
      if (byte_last) begin
        word_cnt <= word_cnt + LEN_WIDTH'(1);
        if (!wr_in_range) load_err <= 1'b1;
      end
    end
  end

  // Array ports carry no reset so the memory maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (fetch_take && !flush && !fetch_bad) rd_word <= mem[fetch_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid  <= 1'b0;
      inst_addr   <= '0;
      fetch_fault <= 1'b0;
      from_mem    <= 1'b0;
    end else if (flush || state != RUN) begin
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      from_mem    <= 1'b0;
    end else if (!stall) begin
      if (fetch_take) begin
        inst_valid  <= 1'b1;
        inst_addr   <= fetch_addr;
        fetch_fault <= fetch_bad;
        from_mem    <= ~fetch_bad;
      end else begin
        inst_valid  <= 1'b0;
        fetch_fault <= 1'b0;
        from_mem    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_sync_loader.sv
// Randomised bench for imem_sync_loader: a word-array model of memory plus
// transaction-level load and per-cycle fetch expectations.
module tb_imem_sync_loader;

  localparam int          AW    = 32;
  localparam int          LW    = 16;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          stall;
  logic          flush;
  logic          fetch_ready;
  logic          inst_valid;
  logic [31:0]   instruction;
  logic [AW-1:0] inst_addr;
  logic          fetch_fault;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [LW-1:0] load_len;
  logic          load_byte_valid;
  logic [7:0]    load_byte;
  logic          load_busy;
  logic          load_done;
  logic          load_err;

  imem_sync_loader #(
    .ADDR_WIDTH(AW), .INST_WIDTH(32), .IMEM_DEPTH(DEPTH),
    .NOP_INST(NOP), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall), .flush(flush),
    .fetch_ready(fetch_ready), .inst_valid(inst_valid), .instruction(instruction),
    .inst_addr(inst_addr), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  int          known_idx [$];
  logic [31:0] load_words [$];
  logic        e_valid, e_fault, e_err;
  logic [31:0] e_inst, e_addr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkFetch(input string ctx);
    checkOutput({ctx, ".inst_valid"},  32'(inst_valid),  32'(e_valid));
    checkOutput({ctx, ".fetch_fault"}, 32'(fetch_fault), 32'(e_fault));
    checkOutput({ctx, ".inst_addr"},   inst_addr,        e_addr);
    checkOutput({ctx, ".instruction"}, instruction,      e_inst);
  endtask

  task automatic resetExpect();
    e_valid = 1'b0; e_fault = 1'b0; e_inst = NOP; e_addr = '0; e_err = 1'b0;
  endtask

  task automatic commitWord(input logic [31:0] idx, input logic [31:0] w);
    if (idx < DEPTH) begin
      ref_mem[idx] = w;
      if (!ref_known[idx]) known_idx.push_back(int'(idx));
      ref_known[idx] = 1'b1;
    end else begin
      e_err = 1'b1;
    end
  endtask

  // One fetch-side cycle in RUN; called at posedge+1, returns at posedge+1.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic st, input logic fl);
    logic [31:0] idx;
    fetch_req = req; fetch_addr = addr; stall = st; flush = fl;
    #1;
    checkOutput("fetch_ready", 32'(fetch_ready), 32'(!st));
    @(posedge clk); #1;
    idx = addr >> 2;
    if (fl) begin
      e_valid = 1'b0; e_inst = NOP; e_fault = 1'b0;
    end else if (!st) begin
      if (req) begin
        e_valid = 1'b1; e_addr = addr;
        if (addr[1:0] != 2'b00 || idx >= DEPTH) begin
          e_fault = 1'b1; e_inst = NOP;
        end else begin
          e_fault = 1'b0; e_inst = ref_mem[idx];
        end
      end else begin
        e_valid = 1'b0; e_inst = NOP; e_fault = 1'b0;
      end
    end
    checkFetch("fetch");
    fetch_req = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  // Whole load transaction using load_words; abort_after >= 0 resets after that many bytes.
  task automatic loadProgram(input logic [31:0] base, input int len, input int abort_after, input logic collide);
    logic [31:0] bidx;
    logic [31:0] cur;
    int          nbytes;
    bidx   = base >> 2;
    nbytes = len * 4;
    load_start = 1'b1; load_base = base; load_len = LW'(len);
    fetch_req = collide; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
    #1;
    checkOutput("ready_on_start", 32'(fetch_ready), 32'd0);
    @(posedge clk); #1;
    load_start = 1'b0; fetch_req = 1'b0;
    e_valid = 1'b0; e_inst = NOP; e_fault = 1'b0; e_err = 1'b0;
    checkOutput("busy_after_start", 32'(load_busy), 32'd1);
    checkOutput("err_cleared", 32'(load_err), 32'd0);
    checkFetch("start");
    if (len == 0) begin
      checkOutput("done_zero_len", 32'(load_done), 32'd1);
    end else begin
      checkOutput("done_early", 32'(load_done), 32'd0);
      for (int b = 0; b < nbytes; b++) begin
        if (b == abort_after) begin
          #2 rst = 1'b1;
          #1;
          resetExpect();
          checkOutput("busy_reset", 32'(load_busy), 32'd0);
          checkOutput("done_reset", 32'(load_done), 32'd0);
          checkOutput("err_reset", 32'(load_err), 32'd0);
          checkFetch("reset_mid_load");
          load_byte_valid = 1'b0;
          @(posedge clk); #2 rst = 1'b0;
          @(posedge clk); #1;
          for (int w = 0; w < b / 4; w++) commitWord(bidx + w, load_words[w]);
          load_words.delete();
          return;
        end
        repeat ($urandom_range(0, 2)) begin
          load_byte_valid = 1'b0;
          fetch_req = 1'($urandom); stall = 1'($urandom); fetch_addr = $urandom;
          #1;
          checkOutput("ready_while_busy", 32'(fetch_ready), 32'd0);
          @(posedge clk); #1;
          checkOutput("busy_gap", 32'(load_busy), 32'd1);
          checkOutput("done_gap", 32'(load_done), 32'd0);
          checkOutput("valid_gap", 32'(inst_valid), 32'd0);
        end
        cur = load_words[b / 4];
        load_byte_valid = 1'b1;
        load_byte = cur[(b % 4) * 8 +: 8];
        fetch_req = 1'($urandom); stall = 1'($urandom);
        @(posedge clk); #1;
        load_byte_valid = 1'b0;
        checkOutput("busy_byte", 32'(load_busy), 32'd1);
        checkOutput("done_byte", 32'(load_done), 32'(b == nbytes - 1));
        checkOutput("valid_byte", 32'(inst_valid), 32'd0);
      end
      for (int w = 0; w < len; w++) commitWord(bidx + w, load_words[w]);
    end
    load_words.delete();
    checkOutput("load_err", 32'(load_err), 32'(e_err));
    fetch_req = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_end", 32'(load_busy), 32'd0);
    checkOutput("done_end", 32'(load_done), 32'd0);
    checkOutput("err_sticky", 32'(load_err), 32'(e_err));
    checkFetch("after_load");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
    load_start = 1'b0; load_base = '0; load_len = '0; load_byte_valid = 1'b0; load_byte = '0;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
    resetExpect();
    #3;
    checkFetch("reset");
    checkOutput("reset.busy", 32'(load_busy), 32'd0);
    checkOutput("reset.done", 32'(load_done), 32'd0);
    checkOutput("reset.err", 32'(load_err), 32'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Directed program load followed by fetches of both words
    load_words.push_back(32'h00100093);
    load_words.push_back(32'h01f00113);
    loadProgram(32'h0, 2, -1, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("word0_const", instruction, 32'h00100093);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    checkOutput("word1_const", instruction, 32'h01f00113);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

    // Stall holds outputs; flush beats stall
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, $urandom, 1'b1, 1'b0);
    checkOutput("stall_hold", instruction, 32'h00100093);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b1);

    // Overflow at the top of the array, then zero-length load clears load_err
    load_words.push_back($urandom);
    load_words.push_back($urandom);
    loadProgram(32'hFFC, 2, -1, 1'b0);
    applyStimulus(1'b1, 32'hFFC, 1'b0, 1'b0);
    loadProgram(32'h40, 0, -1, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);

    // Load bytes in RUN must not disturb memory
    load_byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_byte = 8'($urandom);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    end
    load_byte_valid = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);

    // Reset two bytes into a colliding load
    load_words.push_back($urandom);
    load_words.push_back($urandom);
    loadProgram(32'h0, 2, 2, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("mem0_after_abort", instruction, 32'h00100093);

    // Randomised loads and fetches
    for (int i = 0; i < 32; i++) load_words.push_back($urandom);
    loadProgram(32'h0, 32, -1, 1'($urandom));
    for (int it = 0; it < 400; it++) begin
      if (it % 100 == 99) begin
        r = $urandom_range(1, 6);
        for (int w = 0; w < r; w++) load_words.push_back($urandom);
        loadProgram(($urandom_range(0, 1000) << 2) | $urandom_range(0, 3), r, -1, 1'($urandom));
      end
      r = $urandom_range(0, 99);
      if (r < 70) begin
        a = 32'(known_idx[$urandom_range(0, known_idx.size() - 1)]) << 2;
      end else if (r < 85) begin
        a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      end else begin
        a = $urandom;
        if (a < 32'h1000) a = a + 32'h1000;
      end
      applyStimulus($urandom_range(0, 99) < 85, a,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
